// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-width encodings,
// requester identity and the default burst limit.
package dmem_pkg;

    // DMCtrl access width / sign encodings
    localparam logic [2:0] DMCTRL_BYTE   = 3'b000;
    localparam logic [2:0] DMCTRL_HALF   = 3'b001;
    localparam logic [2:0] DMCTRL_WORD   = 3'b010;
    localparam logic [2:0] DMCTRL_BYTE_U = 3'b100;
    localparam logic [2:0] DMCTRL_HALF_U = 3'b101;

    // Default number of back-to-back grants one side may take while contested
    localparam int MAX_BURST_DEFAULT = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // One requester's access payload, as captured on its grant edge
    typedef struct packed {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port.
// slave  : the arbiter's view.
// master : the requesters' and the memory's view.
interface dmem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_ctrl;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_ctrl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic [31:0] DataRd;

    modport slave (
        input  c_req, c_we, c_ctrl, c_addr, c_wdata,
        input  d_req, d_we, d_ctrl, d_addr, d_wdata,
        input  DataRd,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output DMWr, DMCtrl, Address, DataWr
    );

    modport master (
        output c_req, c_we, c_ctrl, c_addr, c_wdata,
        output d_req, d_we, d_ctrl, d_addr, d_wdata,
        output DataRd,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  DMWr, DMCtrl, Address, DataWr
    );
endinterface

// File: rtl/dmem_arbiter_fairness.sv
// Winner selection between CPU and DMA.
// The CPU wins ties, but an owner that has held a contested bus for
// MAX_BURST grants in a row must yield. Once the other side has taken over,
// it keeps the bus until its own burst runs out. An uncontested requester is
// always granted.
module arb_fairness
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_c_req,
    input  logic   i_d_req,
    output logic   o_any,
    output owner_e o_winner
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

    logic [CW-1:0] r_cnt;
    owner_e        r_last;
    logic          w_contested;
    owner_e        w_winner;

    assign o_any    = i_c_req | i_d_req;
    assign o_winner = w_winner;

    // Pick this cycle's winner from the requests and the running burst
    always_comb begin
        w_contested = i_c_req & i_d_req;
        w_winner    = OWN_CPU;
        if (w_contested) begin
            if (r_cnt >= CNT_MAX) begin
                w_winner = other_owner(r_last);
            end else if (r_cnt != CNT_ZERO) begin
                w_winner = r_last;
            end else begin
                w_winner = OWN_CPU;
            end
        end else if (i_d_req) begin
            w_winner = OWN_DMA;
        end else begin
            w_winner = OWN_CPU;
        end
    end

    // Track the last owner and the length of its contested burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= CNT_ZERO;
            r_last <= OWN_CPU;
        end else if (!o_any) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_last <= w_winner;
            if (!w_contested) begin
                r_cnt <= CNT_ZERO;
            end else if (w_winner != r_last) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// A grant in cycle t drives the memory port from registers in t+1. A read
// samples DataRd at the end of t+1, and its rvalid pulses in t+2. Read
// responses are routed by an owner tag that travels with the access, so a
// change of owner between back-to-back reads cannot misroute data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    logic   w_any;
    owner_e w_win;
    req_t   w_c_pl;
    req_t   w_d_pl;
    req_t   w_sel;

    // Issue stage
    logic [31:0] r_addr;
    logic [2:0]  r_ctrl;
    logic [31:0] r_wdata;
    logic        r_dmwr;
    logic        r_rd_pend;
    owner_e      r_rd_own;

    // Response stage
    logic        r_c_rvalid;
    logic        r_d_rvalid;
    logic [31:0] r_c_rdata;
    logic [31:0] r_d_rdata;

    arb_fairness #(.MAX_BURST(MAX_BURST)) u_fair (
        .clk      (clk),
        .rst      (rst),
        .i_c_req  (bus.c_req),
        .i_d_req  (bus.d_req),
        .o_any    (w_any),
        .o_winner (w_win)
    );

    assign w_c_pl = {bus.c_we, bus.c_ctrl, bus.c_addr, bus.c_wdata};
    assign w_d_pl = {bus.d_we, bus.d_ctrl, bus.d_addr, bus.d_wdata};
    assign w_sel  = (w_win == OWN_DMA) ? w_d_pl : w_c_pl;

    // Grants are forced low while reset is asserted, whatever the requests
    assign bus.c_gnt = ~rst & w_any & (w_win == OWN_CPU);
    assign bus.d_gnt = ~rst & w_any & (w_win == OWN_DMA);

    assign bus.Address  = r_addr;
    assign bus.DMCtrl   = r_ctrl;
    assign bus.DataWr   = r_wdata;
    assign bus.DMWr     = r_dmwr;
    assign bus.c_rvalid = r_c_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.c_rdata  = r_c_rdata;
    assign bus.d_rdata  = r_d_rdata;

    // Capture the winner's payload; the address and width hold while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= 32'h0000_0000;
            r_ctrl    <= 3'b000;
            r_wdata   <= 32'h0000_0000;
            r_dmwr    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_own  <= OWN_CPU;
        end else if (w_any) begin
            r_addr    <= w_sel.addr;
            r_ctrl    <= w_sel.ctrl;
            r_wdata   <= w_sel.wdata;
            r_dmwr    <= w_sel.we;
            r_rd_pend <= ~w_sel.we;
            r_rd_own  <= w_win;
        end else begin
            r_dmwr    <= 1'b0;
            r_rd_pend <= 1'b0;
        end
    end

    // Register read data to the tagged owner; rdata holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= 32'h0000_0000;
            r_d_rdata  <= 32'h0000_0000;
        end else begin
            r_c_rvalid <= r_rd_pend & (r_rd_own == OWN_CPU);
            r_d_rvalid <= r_rd_pend & (r_rd_own == OWN_DMA);
            if (r_rd_pend && (r_rd_own == OWN_CPU)) begin
                r_c_rdata <= bus.DataRd;
            end else begin
                r_c_rdata <= r_c_rdata;
            end
            if (r_rd_pend && (r_rd_own == OWN_DMA)) begin
                r_d_rdata <= bus.DataRd;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// The driver holds each request until it is granted and predicts grants with
// a burst/priority reference model. On every grant it queues the expected
// memory-port activity and read response. A separate monitor pops the queues
// and compares them with what the DUT presents.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int MB = 4;

    typedef struct {
        bit          v;
        bit          we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pend_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] env_mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic [2:0]  ctrl_tab [0:4];
    exp_t        iq[$];
    exp_t        cq[$];
    exp_t        dq[$];
    pend_t       pc;
    pend_t       pd;
    logic [31:0] exp_addr;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_c_rdata;
    logic [31:0] exp_d_rdata;
    int          m_run;
    owner_e      m_own;
    string       gstr;

    // Clock generation
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory: combinational read, write on DMWr
    assign bus.DataRd = env_mem[bus.Address[5:2]];
    always @(posedge clk) begin
        if (bus.DMWr) env_mem[bus.Address[5:2]] <= bus.DataWr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pend_t mk(input bit we, input int idx, input logic [31:0] data);
        pend_t p;
        p.v     = 1'b1;
        p.we    = we;
        p.ctrl  = ctrl_tab[$urandom_range(0, 4)];
        p.addr  = 32'(idx) << 2;
        p.wdata = data;
        return p;
    endfunction

    // Reference arbitration: CPU wins a tie unless the holder has used up its
    // burst; a holder keeps a contested bus until its burst limit is reached.
    task automatic model_pick(input bit c, input bit d, output bit any, output owner_e win);
        any = c | d;
        win = OWN_CPU;
        if (c && d) begin
            if (m_run >= MB)     win = (m_own == OWN_CPU) ? OWN_DMA : OWN_CPU;
            else if (m_run > 0)  win = m_own;
            else                 win = OWN_CPU;
            m_run = (win == m_own) ? m_run + 1 : 1;
        end else begin
            win   = d ? OWN_DMA : OWN_CPU;
            m_run = 0;
        end
        if (any) m_own = win;
    endtask

    // One bus cycle: drive pending requests, predict, check grants
    task automatic run_cycle();
        bit     any, gc, gd;
        owner_e win;
        pend_t  s;
        exp_t   e;
        bus.c_req = pc.v; bus.c_we = pc.we; bus.c_ctrl = pc.ctrl; bus.c_addr = pc.addr; bus.c_wdata = pc.wdata;
        bus.d_req = pd.v; bus.d_we = pd.we; bus.d_ctrl = pd.ctrl; bus.d_addr = pd.addr; bus.d_wdata = pd.wdata;
        model_pick(pc.v, pd.v, any, win);
        gc = any && (win == OWN_CPU);
        gd = any && (win == OWN_DMA);
        if (any) begin
            s = gc ? pc : pd;
            e.cyc = cyc + 1; e.we = s.we; e.ctrl = s.ctrl; e.addr = s.addr; e.data = s.wdata;
            iq.push_back(e);
            if (s.we) begin
                ref_mem[s.addr[5:2]] = s.wdata;
            end else begin
                e.cyc = cyc + 2; e.data = ref_mem[s.addr[5:2]];
                if (gc) cq.push_back(e); else dq.push_back(e);
            end
        end
        gstr = {gstr, gc ? "C" : (gd ? "D" : "-")};
        @(negedge clk);
        chk("c_gnt", 32'(bus.c_gnt), 32'(gc));
        chk("d_gnt", 32'(bus.d_gnt), 32'(gd));
        @(posedge clk); #1;
        if (gc) pc.v = 1'b0;
        if (gd) pd.v = 1'b0;
    endtask

    task automatic do_reset(input int n, input bit hold_req);
        rst = 1'b1;
        pc.v = 1'b0; pd.v = 1'b0;
        bus.c_req = hold_req; bus.d_req = hold_req;
        iq.delete(); cq.delete(); dq.delete();
        m_run = 0; m_own = OWN_CPU;
        exp_addr = 32'h0; exp_ctrl = 3'b000; exp_c_rdata = 32'h0; exp_d_rdata = 32'h0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.c_req = 1'b0; bus.d_req = 1'b0;
    endtask

    // Monitor: compare memory-port and response activity against the queues
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_c_gnt", 32'(bus.c_gnt), 32'h0);
            chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
            chk("rst_dmwr", 32'(bus.DMWr), 32'h0);
            chk("rst_rvalid", 32'({bus.c_rvalid, bus.d_rvalid}), 32'h0);
            chk("rst_addr", bus.Address, 32'h0);
            chk("rst_wdata", bus.DataWr, 32'h0);
            chk("rst_ctrl", 32'(bus.DMCtrl), 32'h0);
            chk("rst_rdata", bus.c_rdata | bus.d_rdata, 32'h0);
        end else begin
            if (iq.size() != 0 && iq[0].cyc == cyc) begin
                e = iq.pop_front();
                chk("iss_addr", bus.Address, e.addr);
                chk("iss_ctrl", 32'(bus.DMCtrl), 32'(e.ctrl));
                chk("iss_dmwr", 32'(bus.DMWr), 32'(e.we));
                if (e.we) chk("iss_wdata", bus.DataWr, e.data);
                exp_addr = e.addr;
                exp_ctrl = e.ctrl;
            end else begin
                chk("idle_dmwr", 32'(bus.DMWr), 32'h0);
                chk("hold_addr", bus.Address, exp_addr);
                chk("hold_ctrl", 32'(bus.DMCtrl), 32'(exp_ctrl));
            end
            if (bus.c_rvalid) begin
                if (cq.size() == 0) chk("c_rvalid_unexp", 32'(bus.c_rvalid), 32'h0);
                else begin
                    e = cq.pop_front();
                    chk("c_rvalid_cyc", cyc, e.cyc);
                    chk("c_rdata", bus.c_rdata, e.data);
                    exp_c_rdata = e.data;
                end
            end else begin
                chk("c_rdata_hold", bus.c_rdata, exp_c_rdata);
                if (cq.size() != 0 && cq[0].cyc <= cyc) begin
                    e = cq.pop_front();
                    chk("c_rvalid_miss", 32'(bus.c_rvalid), 32'h1);
                end
            end
            if (bus.d_rvalid) begin
                if (dq.size() == 0) chk("d_rvalid_unexp", 32'(bus.d_rvalid), 32'h0);
                else begin
                    e = dq.pop_front();
                    chk("d_rvalid_cyc", cyc, e.cyc);
                    chk("d_rdata", bus.d_rdata, e.data);
                    exp_d_rdata = e.data;
                end
            end else begin
                chk("d_rdata_hold", bus.d_rdata, exp_d_rdata);
                if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                    e = dq.pop_front();
                    chk("d_rvalid_miss", 32'(bus.d_rvalid), 32'h1);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        string exp_pat;
        ctrl_tab[0] = DMCTRL_BYTE;   ctrl_tab[1] = DMCTRL_HALF; ctrl_tab[2] = DMCTRL_WORD;
        ctrl_tab[3] = DMCTRL_BYTE_U; ctrl_tab[4] = DMCTRL_HALF_U;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        env_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        pc = '{default: 0};
        pd = '{default: 0};
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_ctrl = 3'b000; bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_ctrl = 3'b000; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        do_reset(2, 1'b1);

        // Lone CPU read of 0x10
        pc = mk(1'b0, 4, 32'h0);
        run_cycle();
        repeat (3) run_cycle();

        // Both sides write continuously: bursts of four alternate
        do_reset(1, 1'b0);
        gstr = "";
        for (int i = 0; i < 9; i++) begin
            if (!pc.v) pc = mk(1'b1, 10 + (i % 2), $urandom);
            if (!pd.v) pd = mk(1'b1, 12 + (i % 2), $urandom);
            run_cycle();
        end
        exp_pat = "CCCCDDDDC";
        for (int i = 0; i < 9; i++) chk("burst_pattern", 32'(gstr[i]), 32'(exp_pat[i]));
        pc.v = 1'b0; pd.v = 1'b0;
        repeat (3) run_cycle();

        // DMA write 0x20 <= 0x55, then CPU read of 0x20
        pd = mk(1'b1, 8, 32'h0000_0055);
        run_cycle();
        pc = mk(1'b0, 8, 32'h0);
        run_cycle();
        repeat (3) run_cycle();

        // Alternating single reads C, D, C from distinct words
        pc = mk(1'b0, 1, 32'h0); run_cycle();
        pd = mk(1'b0, 2, 32'h0); run_cycle();
        pc = mk(1'b0, 3, 32'h0); run_cycle();
        repeat (3) run_cycle();

        // Reset in the cycle after a CPU read grant discards the read
        pc = mk(1'b0, 5, 32'h0);
        run_cycle();
        do_reset(2, 1'b1);
        repeat (3) run_cycle();

        // Lone DMA for ten cycles is granted every cycle
        for (int i = 0; i < 10; i++) begin
            pd = mk(i[0], i % 16, $urandom);
            run_cycle();
        end
        repeat (3) run_cycle();

        // Randomized traffic with hold-until-grant requesters
        for (int i = 0; i < 400; i++) begin
            if (!pc.v && $urandom_range(0, 9) < 7) pc = mk($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
            if (!pd.v && $urandom_range(0, 9) < 7) pd = mk($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
            run_cycle();
        end
        pc.v = 1'b0; pd.v = 1'b0;
        repeat (4) run_cycle();
        chk("queues_drained", 32'(iq.size() + cq.size() + dq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4; maximum consecutive grants to one requester while the other is requesting.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 c_req/c_we  in  1/1  CPU requester: access request / write-enable.
REQ-005 c_ctrl  in  3  CPU access width/sign, DMCtrl encoding.
REQ-006 c_addr/c_wdata  in  32/32  CPU address / write data.
REQ-007 c_gnt/c_rvalid  out  1/1  CPU grant / read data valid.
REQ-008 c_rdata  out  32  CPU read data.
REQ-009 d_req, d_we, d_ctrl, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same directions and widths as REQ-004..008; loader/DMA requester.
REQ-010 DMWr  out  1  data memory write strobe.
REQ-011 DMCtrl  out  3  data memory access width/sign.
REQ-012 Address/DataWr  out  32/32  data memory address / write data.
REQ-013 DataRd  in  32  data memory read data; combinational from Address/DMCtrl.

Function
REQ-014 Grants are combinational from current requests and arbiter state; at most one of c_gnt, d_gnt is high per cycle.
REQ-015 A requester holds req and payload stable until its gnt cycle; the payload is captured on the gnt edge.
REQ-016 Grant in cycle t drives Address/DMCtrl/DataWr from registers in cycle t+1; DMWr is high in t+1 for writes only.
REQ-017 A granted read samples DataRd at the end of t+1; the owner's rvalid is a one-cycle pulse in t+2 with rdata registered; read latency is 2 cycles from grant.
REQ-018 Writes never produce rvalid.
REQ-019 rdata holds its last value when rvalid is low.
REQ-020 With no grant, DMWr is 0 in the following cycle; Address, DMCtrl and DataWr hold their last values.
REQ-021 Priority: the CPU wins when both request, unless the fairness rule in REQ-022 applies.
REQ-022 Burst counter counts consecutive grants to the same owner while the other requester is high; once it reaches MAX_BURST, the other requester wins the next contested cycle and the counter restarts at 1 for the new owner.
REQ-023 The burst counter clears to 0 on any cycle where the non-owner is not requesting, or on an idle cycle.
REQ-024 Back-to-back grants every cycle are supported; the pipeline has no bubbles.
REQ-025 If the owner changes between consecutive reads, rvalid is routed by a per-stage owner tag, never by the current grant.
REQ-026 A lone requester is granted every cycle regardless of the counter.

Reset
REQ-027 rst high immediately sets c_gnt/d_gnt inputs-independent low, all rvalid low, DMWr 0, Address/DataWr/DMCtrl/rdata 0, burst counter 0, last owner = CPU.
REQ-028 Reset mid-operation discards in-flight accesses: no rvalid and no DMWr occur after rst deasserts for pre-reset grants.
REQ-029 The first rising edge after rst deasserts may grant.

Structure
REQ-030 Shared package dmem_pkg holds DMCtrl encodings (000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned), the owner enum (OWN_CPU, OWN_DMA) and the MAX_BURST default.
REQ-031 Fairness counter and owner selection live in one sub-module, arb_fairness, which outputs a winner select.
REQ-032 Issue and response stages are inline registers in dmem_arbiter.

Verification
REQ-033 CPU read only, addr 0x10, DataRd=0xDEADBEEF -> c_gnt same cycle, Address=0x10 at t+1, c_rvalid with 0xDEADBEEF at t+2, d_* quiet.
REQ-034 Both requesters write continuously, MAX_BURST=4 -> grant pattern C,C,C,C,D,D,D,D,C…; DMWr high every cycle after the first.
REQ-035 DMA write 0x20<=0x55, then CPU read 0x20 on the next cycle -> DMWr at t+1, CPU read returns 0x55 with c_rvalid at t+3, d_rvalid never high.
REQ-036 Alternating reads C,D,C with distinct DataRd -> each rvalid goes to the correct owner with the correct data, one per cycle.
REQ-037 rst asserted in the cycle after a CPU read grant -> no c_rvalid afterwards; all outputs 0 while rst is high.
REQ-038 d_req held alone for 10 cycles -> d_gnt every cycle; the counter does not block.
